// File: rtl/assoc_cache.sv
// assoc_cache: set-associative, write-back, write-allocate data cache with tree
// pseudo-LRU replacement, sub-word stores and a line-wide req/ack memory port.
module assoc_cache #(
    parameter int WIDTH      = 32,
    parameter int SETS       = 256,
    parameter int WAYS       = 2,
    parameter int LINE_BYTES = 8,
    parameter int ADDR_W     = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        addr,
    input  logic [WIDTH-1:0]        write_data,
    input  logic [2:0]              modeAddr,
    input  logic                    WE,
    input  logic                    RE,
    output logic                    miss_stall,
    output logic [WIDTH-1:0]        cache_out,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*LINE_BYTES-1:0] mem_wdata,
    input  logic [8*LINE_BYTES-1:0] mem_rdata,
    input  logic                    mem_ack,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PL_W   = (WAYS > 1) ? WAYS - 1 : 1;
    localparam logic [OFF_W-1:0] ALIGN = ~OFF_W'(3);

    typedef enum logic [1:0] {LOOKUP, WRITE_BACK, ALLOCATE} state_t;
    state_t state_q, state_d;

    logic [LINE_W-1:0]         data_q [WAYS][SETS];
    logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
    logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
    logic [SETS-1:0][PL_W-1:0] plru_q;
    logic [WAY_W-1:0]          vict_q, hit_way, inv_way, plru_way, vict;
    logic [ADDR_W-1:0]         mem_addr_q, fill_addr;
    logic [LINE_W-1:0]         mem_wdata_q, hit_line, st_line;
    logic [31:0]               hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    logic [IDX_W-1:0]          idx;
    logic [TAG_W-1:0]          tag;
    logic [OFF_W-1:0]          off_al;
    logic [WAYS-1:0]           hit_vec;
    logic [PL_W-1:0]           pl, pl_upd;
    logic [3:0]                be4;
    logic [31:0]               wd32;
    logic                      access, hit, lk_hit, lk_miss, byte_m, half_m, vdirty;
    logic                      unused_hi;

    assign unused_hi = ^addr[WIDTH-1:ADDR_W];
    assign idx       = addr[OFF_W +: IDX_W];
    assign tag       = addr[OFF_W+IDX_W +: TAG_W];
    assign off_al    = addr[OFF_W-1:0] & ALIGN;
    assign fill_addr = {tag, idx, {OFF_W{1'b0}}};
    assign access    = RE | WE;
    assign hit       = |hit_vec;
    assign lk_hit    = state_q == LOOKUP && access && hit;
    assign lk_miss   = state_q == LOOKUP && access && !hit;
    assign pl        = plru_q[idx];
    assign hit_line  = data_q[hit_way][idx];

    // Scanning from the top down leaves the lowest-index invalid way in inv_way.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid_q[idx][w] && tag_q[w][idx] == tag;
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_q[idx][w]) inv_way = WAY_W'(w);
        end
    end

    // Tree bits point at the least-recently-used side; a touch points them away.
    if (WAYS == 4) begin : g_plru4
        assign plru_way = pl[0] ? {1'b1, pl[2]} : {1'b0, pl[1]};
        always_comb begin
            pl_upd    = pl;
            pl_upd[0] = ~hit_way[1];
            if (hit_way[1]) pl_upd[2] = ~hit_way[0];
            else pl_upd[1] = ~hit_way[0];
        end
    end else if (WAYS == 2) begin : g_plru2
        assign plru_way = pl[0];
        assign pl_upd   = ~hit_way[0];
    end else begin : g_plru1
        assign plru_way = '0;
        assign pl_upd   = pl;
    end

    assign vict   = &valid_q[idx] ? plru_way : inv_way;
    assign vdirty = dirty_q[idx][vict];

    assign byte_m = modeAddr == 3'b011 || modeAddr == 3'b101;
    assign half_m = modeAddr == 3'b001 || modeAddr == 3'b100;
    assign be4    = byte_m ? 4'b0001 << addr[1:0] : half_m ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd32   = byte_m ? {4{write_data[7:0]}} : half_m ? {2{write_data[15:0]}} : write_data;

    always_comb begin
        st_line = hit_line;
        for (int b = 0; b < LINE_BYTES; b++)
            if (be4[b % 4] && (OFF_W'(b) & ALIGN) == off_al) st_line[b*8 +: 8] = wd32[(b % 4)*8 +: 8];
    end

    always_comb begin
        state_d = state_q;
        if (state_q == LOOKUP) state_d = lk_miss ? (vdirty ? WRITE_BACK : ALLOCATE) : LOOKUP;
        else if (mem_ack) state_d = state_q == WRITE_BACK ? ALLOCATE : LOOKUP;
    end

    always_comb begin
        hit_count_d  = (lk_hit && ~&hit_count_q) ? hit_count_q + 32'd1 : hit_count_q;
        miss_count_d = (lk_miss && ~&miss_count_q) ? miss_count_q + 32'd1 : miss_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOOKUP;
            valid_q      <= '0;
            dirty_q      <= '0;
            plru_q       <= '0;
            vict_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            if (lk_miss) begin
                vict_q      <= vict;
                mem_addr_q  <= vdirty ? {tag_q[vict][idx], idx, {OFF_W{1'b0}}} : fill_addr;
                mem_wdata_q <= data_q[vict][idx];
            end
            if (lk_hit) begin
                plru_q[idx] <= pl_upd;
                if (WE) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (state_q == WRITE_BACK && mem_ack) begin
                dirty_q[idx][vict_q] <= 1'b0;
                mem_addr_q           <= fill_addr;
            end
            if (state_q == ALLOCATE && mem_ack) begin
                valid_q[idx][vict_q] <= 1'b1;
                dirty_q[idx][vict_q] <= 1'b0;
            end
        end
    end

    // Line storage needs no reset: nothing reads it until its valid bit is set.
    always_ff @(posedge clk) begin
        if (lk_hit && WE) data_q[hit_way][idx] <= st_line;
        if (state_q == ALLOCATE && mem_ack) begin
            data_q[vict_q][idx] <= mem_rdata;
            tag_q[vict_q][idx]  <= tag;
        end
    end

    always_comb begin
        mem_req    = state_q != LOOKUP;
        mem_we     = state_q == WRITE_BACK;
        miss_stall = state_q != LOOKUP || (access && !hit);
        cache_out  = (lk_hit && RE) ? hit_line[{off_al, 3'b000} +: WIDTH] : '0;
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed vector table plus hand-written miss, eviction,
// reset and saturation sequences for assoc_cache at default parameters.
module tb_assoc_cache;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic [31:0] addr = '0, write_data = '0;
    logic [2:0]  modeAddr = '0;
    logic        WE = 1'b0, RE = 1'b0;
    logic        miss_stall, mem_req, mem_we;
    logic [31:0] cache_out, hit_count, miss_count;
    logic [16:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    assoc_cache dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data),
        .modeAddr(modeAddr), .WE(WE), .RE(RE), .miss_stall(miss_stall),
        .cache_out(cache_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {
        logic [31:0] a;
        logic        re;
        logic        we;
        logic [2:0]  m;
        logic [31:0] d;
        logic [31:0] want;
    } vec_t;
    vec_t tv [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, want);
    endtask

    task automatic drive(input logic [31:0] a, input logic re, input logic we, input logic [2:0] m, input logic [31:0] d);
        addr = a; RE = re; WE = we; modeAddr = m; write_data = d;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk); #1;
        drive(v.a, v.re, v.we, v.m, v.d);
        #1;
        check($sformatf("stall @%0h", v.a), miss_stall, 0);
        check($sformatf("cache_out @%0h", v.a), cache_out, v.want);
    endtask

    task automatic start(input logic [31:0] a, input logic re, input logic we, input logic [2:0] m, input logic [31:0] d);
        @(negedge clk); #1;
        drive(a, re, we, m, d);
        #1;
        check($sformatf("miss stall @%0h", a), miss_stall, 1);
        check($sformatf("no req yet @%0h", a), mem_req, 0);
    endtask

    task automatic serve(input logic we, input logic [16:0] a, input logic [63:0] wd, input logic [63:0] rd, input int lat);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk); #1;
            check($sformatf("mem_req @%0h", a), mem_req, 1);
            check($sformatf("mem_we @%0h", a), mem_we, we);
            check("mem_addr", mem_addr, a);
            if (we) check("mem_wdata", mem_wdata, wd);
            check("stall during mem", miss_stall, 1);
        end
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk); #1;
        mem_ack = 1'b0;
    endtask

    task automatic done(input logic [31:0] want);
        #1;
        check("stall after fill", miss_stall, 0);
        check("req dropped", mem_req, 0);
        check("out after fill", cache_out, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{32'h14,   1'b1, 1'b0, 3'b010, 32'h0,        32'h89ABCDEF};
        tv[1]  = '{32'h11,   1'b0, 1'b1, 3'b011, 32'hAA,       32'h0};
        tv[2]  = '{32'h16,   1'b0, 1'b1, 3'b001, 32'hBEEF,     32'h0};
        tv[3]  = '{32'h10,   1'b1, 1'b0, 3'b010, 32'h0,        32'h0123AA67};
        tv[4]  = '{32'h14,   1'b1, 1'b0, 3'b010, 32'h0,        32'hBEEFCDEF};
        tv[5]  = '{32'h1013, 1'b0, 1'b1, 3'b101, 32'h11,       32'h0};
        tv[6]  = '{32'h1011, 1'b0, 1'b1, 3'b100, 32'h2222,     32'h0};
        tv[7]  = '{32'h1010, 1'b1, 1'b0, 3'b111, 32'h0,        32'h11DC2222};
        tv[8]  = '{32'h1017, 1'b1, 1'b1, 3'b000, 32'hCAFEF00D, 32'h76543210};
        tv[9]  = '{32'h1014, 1'b1, 1'b0, 3'b000, 32'h0,        32'hCAFEF00D};
        tv[10] = '{32'h10,   1'b1, 1'b0, 3'b010, 32'h0,        32'h01234567};
        tv[11] = '{32'h10,   1'b1, 1'b0, 3'b010, 32'h0,        32'h01234567};

        #1 rst_n = 1'b0;
        #1;
        check("reset mem_req", mem_req, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset hit_count", hit_count, 0);
        check("reset miss_count", miss_count, 0);
        check("reset stall", miss_stall, 0);
        check("reset cache_out", cache_out, 0);
        @(negedge clk); @(negedge clk); #1 rst_n = 1'b1;

        // clean fill, then hits and sub-word stores on the filled line
        start(32'h10, 1'b1, 1'b0, 3'b010, 32'h0);
        serve(1'b0, 17'h10, 64'h0, 64'h89ABCDEF_01234567, 3);
        done(32'h01234567);
        apply(tv[0]);
        @(negedge clk); #1;
        drive(32'h0, 1'b0, 1'b0, 3'b000, 32'h0);
        check("hit_count after fill", hit_count, 2);
        check("miss_count after fill", miss_count, 1);
        for (int i = 1; i <= 4; i++) apply(tv[i]);

        // fill way 1, then evict dirty way 0
        start(32'h810, 1'b1, 1'b0, 3'b010, 32'h0);
        serve(1'b0, 17'h810, 64'h0, 64'h0BADF00D_DEADBEEF, 0);
        done(32'hDEADBEEF);
        start(32'h1010, 1'b1, 1'b0, 3'b010, 32'h0);
        serve(1'b1, 17'h10, 64'hBEEFCDEF_0123AA67, 64'h0, 1);
        serve(1'b0, 17'h1010, 64'h0, 64'h76543210_FEDCBA98, 0);
        done(32'hFEDCBA98);
        for (int i = 5; i <= 9; i++) apply(tv[i]);

        // re-read of the evicted line misses; reset lands mid-allocate
        start(32'h10, 1'b1, 1'b0, 3'b010, 32'h0);
        @(negedge clk); #1;
        check("realloc mem_req", mem_req, 1);
        check("realloc mem_we", mem_we, 0);
        check("realloc mem_addr", mem_addr, 17'h10);
        drive(32'h10, 1'b0, 1'b0, 3'b010, 32'h0);
        rst_n = 1'b0;
        #1;
        check("async reset mem_req", mem_req, 0);
        check("async reset hit_count", hit_count, 0);
        check("async reset miss_count", miss_count, 0);
        check("async reset mem_addr", mem_addr, 0);
        mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk); #1;
        mem_ack = 1'b0; rst_n = 1'b1;
        start(32'h10, 1'b1, 1'b0, 3'b010, 32'h0);
        serve(1'b0, 17'h10, 64'h0, 64'h89ABCDEF_01234567, 1);
        done(32'h01234567);
        check("post-reset miss_count", miss_count, 1);
        check("post-reset hit_count", hit_count, 0);

        // PLRU: 0x810 written into way 1, 0x10 touched, 0x1810 must evict way 1
        start(32'h810, 1'b0, 1'b1, 3'b010, 32'h5555AAAA);
        serve(1'b0, 17'h810, 64'h0, 64'h0BADF00D_DEADBEEF, 0);
        done(32'h0);
        apply(tv[10]);
        start(32'h1810, 1'b1, 1'b0, 3'b010, 32'h0);
        serve(1'b1, 17'h810, 64'h0BADF00D_5555AAAA, 64'h0, 0);
        serve(1'b0, 17'h1810, 64'h0, 64'h13579BDF_2468ACE0, 0);
        done(32'h2468ACE0);
        apply(tv[11]);

        // idle cycles change nothing
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            drive($urandom, 1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom);
            #1;
            check("idle mem_req", mem_req, 0);
            check("idle stall", miss_stall, 0);
            check("idle cache_out", cache_out, 0);
        end
        check("idle hit_count", hit_count, 5);
        check("idle miss_count", miss_count, 3);

        // saturation of the hit counter
        @(negedge clk); #1;
        force dut.hit_count_q = 32'hFFFF_FFFF;
        #1 release dut.hit_count_q;
        drive(32'h10, 1'b1, 1'b0, 3'b010, 32'h0);
        #1;
        check("sat hit stall", miss_stall, 0);
        check("sat hit out", cache_out, 32'h01234567);
        @(negedge clk); #1;
        drive(32'h0, 1'b0, 1'b0, 3'b000, 32'h0);
        check("hit_count saturated", hit_count, 32'hFFFF_FFFF);
        check("miss_count after sat", miss_count, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- Parametrised set-associative, write-back, write-allocate data cache between the single-cycle core's load/store path and a line-wide backing-memory port with a req/ack handshake.
- Generalises the direct-mapped cache: configurable sets, ways and line size, tree pseudo-LRU replacement, byte/half/word stores, and hit/miss counters.
- Misses take a variable number of cycles; the core is frozen by miss_stall.

Parameters:
- WIDTH, 32, CPU data width (fixed at 32).
- SETS, 256, number of sets; power of 2.
- WAYS, 2, associativity; one of 1, 2, 4.
- LINE_BYTES, 8, bytes per line; power of 2, at least 4.
- ADDR_W, 17, byte-address width of backing memory.
- Derived: OFF_W = log2(LINE_BYTES), IDX_W = log2(SETS), TAG_W = ADDR_W - IDX_W - OFF_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  WIDTH  byte address; bits above ADDR_W ignored.
- write_data  in  WIDTH  store data, right-aligned.
- modeAddr  in  3  store size: 3'b011/3'b101 byte; 3'b001/3'b100 halfword; else word.
- WE  in  1  store request.
- RE  in  1  load request.
- miss_stall  out  1  combinational; high while the current access is not complete.
- cache_out  out  WIDTH  aligned word containing addr on a read hit; 0 otherwise.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = line write-back, 0 = line fill.
- mem_addr  out  ADDR_W  line-aligned address (low OFF_W bits 0).
- mem_wdata  out  8*LINE_BYTES  victim line, little-endian.
- mem_rdata  in  8*LINE_BYTES  fill line, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.
- hit_count  out  32  saturating count of hit accesses.
- miss_count  out  32  saturating count of miss events.

Behaviour:
- Reset (async, rst_n low):
  - all valid, dirty and PLRU bits clear; state returns to LOOKUP.
  - mem_req, mem_we, mem_addr, mem_wdata, counters go to 0 immediately.
  - miss_stall and cache_out are 0 while RE/WE are low.
  - Reset mid-miss abandons the transaction; no line is written.
- Address split: offset = addr[OFF_W-1:0], index = next IDX_W bits, tag = next TAG_W bits. Access size is not checked for alignment; word accesses ignore addr[1:0], halfword accesses ignore addr[0].
- Idle cycle (RE=0 and WE=0): never stalls, never misses, no state change.
- States: LOOKUP, WRITE_BACK, ALLOCATE.
- LOOKUP, hit (valid and tag match in exactly one way):
  - miss_stall = 0; cache_out = selected word, same cycle.
  - A store updates only the addressed byte lanes and sets dirty on the clock edge.
  - PLRU is updated to mark the hit way most-recent; hit_count increments.
- LOOKUP, miss:
  - miss_stall = 1; miss_count increments once.
  - Victim = lowest-index invalid way, else the PLRU way.
  - Victim dirty: latch mem_addr = {victim tag, index, 0} and mem_wdata, go to WRITE_BACK. Otherwise go to ALLOCATE.
- WRITE_BACK: mem_req = 1, mem_we = 1; mem_addr and mem_wdata held stable until mem_ack. On ack, clear the victim's dirty bit and go to ALLOCATE.
- ALLOCATE: mem_req = 1, mem_we = 0, mem_addr = {tag, index, 0}. On ack, write mem_rdata into the victim way with valid = 1, dirty = 0, new tag, and return to LOOKUP. The pending access then hits on the following cycle.
- mem_req drops in the cycle after ack; it is never deasserted before ack.
- Minimum miss latency: clean miss = 2 stall cycles with zero-wait memory; dirty miss adds write-back cycles.
- The core holds addr, WE, RE, modeAddr and write_data stable while miss_stall = 1.
- RE and WE together are treated as a store; cache_out still returns the pre-store word.
- Counters saturate at 32'hFFFF_FFFF.

Test Plan:
- Clean fill and hit:
  - Stimulus: after reset, RE at 0x00010, ack 3 cycles later with mem_rdata = 64'h89ABCDEF_01234567.
  - Required: mem_req = 1, mem_we = 0, mem_addr = 0x00010 until ack.
  - Then: one cycle later miss_stall = 0, cache_out = 0x01234567; RE at 0x00014 returns 0x89ABCDEF with no stall; hit_count = 2, miss_count = 1.
- Byte and halfword stores:
  - Stimulus: byte store 0xAA at 0x00011 (modeAddr 3'b011), then halfword store 0xBEEF at 0x00016.
  - Required: no stall; reads return 0x0123AA67 and 0xBEEFCDEF.
- Dirty eviction (default parameters):
  - Stimulus: read 0x00810 (same set, fills way 1), then read 0x01010.
  - Required: victim = way 0; mem_we = 1, mem_addr = 0x00010, mem_wdata = 64'hBEEFCDEF_0123AA67.
  - Then: ALLOCATE at 0x01010, and a re-read of 0x00010 misses.
- PLRU ordering:
  - Stimulus: fill 0x00810, touch 0x00010, then access 0x01810.
  - Required: way 1 (tag of 0x00810) is evicted, not way 0.
- Reset mid-ALLOCATE:
  - Stimulus: pull rst_n low while mem_req = 1.
  - Required: mem_req falls without waiting for a clock; after release, RE at 0x00010 misses again; counters = 0.
- Idle and saturation:
  - Stimulus: RE = WE = 0 with arbitrary addr for 10 cycles; separately, force hit_count to 32'hFFFF_FFFF.
  - Required: idle gives no mem_req, miss_stall = 0, counters unchanged; a further hit leaves hit_count at 32'hFFFF_FFFF.
